// File: rtl/vga_plot_arbiter.sv
// Shares one VGA adapter write port between two cell-drawing requesters and a full-screen clear.
// Cells expand to CELL_WIDTH x CELL_WIDTH plots. Requesters are served round-robin; a pending clear wins at cell boundaries.
module vga_plot_arbiter #(
    parameter int         SCREEN_WIDTH  = 320,
    parameter int         SCREEN_HEIGHT = 240,
    parameter int         CELL_WIDTH    = 5,
    parameter logic [8:0] CLEAR_COLOUR  = 9'h1FF
) (
    input  logic                             iClk,
    input  logic                             iResetn,
    input  logic [1:0]                       iValid,
    input  logic [15:0]                      iCellX,
    input  logic [15:0]                      iCellY,
    input  logic [17:0]                      iColour,
    input  logic                             iClear,
    output logic [1:0]                       oReady,
    output logic [$clog2(SCREEN_WIDTH):0]    oX_pixel,
    output logic [$clog2(SCREEN_HEIGHT):0]   oY_pixel,
    output logic [8:0]                       oColour,
    output logic                             oPlot,
    output logic                             oBusy,
    output logic                             oClearDone,
    output logic                             oDropped
);
    localparam int XW = $clog2(SCREEN_WIDTH) + 1;
    localparam int YW = $clog2(SCREEN_HEIGHT) + 1;
    localparam int DW = (CELL_WIDTH > 1) ? $clog2(CELL_WIDTH) : 1;
    localparam logic [7:0]    MAX_CX = 8'(SCREEN_WIDTH / CELL_WIDTH - 1);
    localparam logic [7:0]    MAX_CY = 8'(SCREEN_HEIGHT / CELL_WIDTH - 1);
    localparam logic [DW-1:0] LAST_D = DW'(CELL_WIDTH - 1);
    localparam logic [XW-1:0] LAST_X = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] LAST_Y = YW'(SCREEN_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, CELL, CLEAR} state_t;

    state_t        r_state;
    logic          r_clear_pending;
    logic          r_last_grant;
    logic [XW-1:0] r_bx;
    logic [YW-1:0] r_by;
    logic [DW-1:0] r_dx;
    logic [DW-1:0] r_dy;

    logic          w_win;
    logic          w_accept;
    logic [7:0]    w_cx;
    logic [7:0]    w_cy;
    logic [8:0]    w_col;
    logic [XW-1:0] w_bx;
    logic [YW-1:0] w_by;

    // Ready is combinational so a requester sees its grant in the same IDLE cycle.
    always_comb begin
        w_win  = 1'b0;
        oReady = 2'b00;
        if (iResetn && r_state == IDLE && !r_clear_pending) begin
            if (iValid == 2'b11) w_win = ~r_last_grant;
            else                 w_win = iValid[1];
            if (iValid != 2'b00) oReady[w_win] = 1'b1;
        end
    end

    assign w_accept = |oReady;
    assign w_cx     = w_win ? iCellX[15:8]  : iCellX[7:0];
    assign w_cy     = w_win ? iCellY[15:8]  : iCellY[7:0];
    assign w_col    = w_win ? iColour[17:9] : iColour[8:0];
    assign w_bx     = XW'(w_cx) * XW'(CELL_WIDTH);
    assign w_by     = YW'(w_cy) * YW'(CELL_WIDTH);
    assign oBusy    = (r_state != IDLE);

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            r_state         <= IDLE;
            r_clear_pending <= 1'b0;
            r_last_grant    <= 1'b1;
            r_bx            <= '0;
            r_by            <= '0;
            r_dx            <= '0;
            r_dy            <= '0;
            oX_pixel        <= '0;
            oY_pixel        <= '0;
            oColour         <= '0;
            oPlot           <= 1'b0;
            oClearDone      <= 1'b0;
            oDropped        <= 1'b0;
        end else begin
            oDropped   <= 1'b0;
            oClearDone <= 1'b0;
            if (iClear && r_state != CLEAR) r_clear_pending <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (r_clear_pending) begin
                        r_state         <= CLEAR;
                        r_clear_pending <= 1'b0;
                        oPlot           <= 1'b1;
                        oX_pixel        <= '0;
                        oY_pixel        <= '0;
                        oColour         <= CLEAR_COLOUR;
                    end else if (w_accept) begin
                        r_last_grant <= w_win;
                        if (w_cx > MAX_CX || w_cy > MAX_CY) begin
                            oDropped <= 1'b1;
                        end else begin
                            r_state  <= CELL;
                            r_bx     <= w_bx;
                            r_by     <= w_by;
                            r_dx     <= '0;
                            r_dy     <= '0;
                            oPlot    <= 1'b1;
                            oX_pixel <= w_bx;
                            oY_pixel <= w_by;
                            oColour  <= w_col;
                        end
                    end
                end
                CELL: begin
                    if (r_dx == LAST_D && r_dy == LAST_D) begin
                        r_state <= IDLE;
                        oPlot   <= 1'b0;
                    end else if (r_dx == LAST_D) begin
                        r_dx     <= '0;
                        r_dy     <= r_dy + DW'(1);
                        oX_pixel <= r_bx;
                        oY_pixel <= r_by + YW'(r_dy) + YW'(1);
                    end else begin
                        r_dx     <= r_dx + DW'(1);
                        oX_pixel <= r_bx + XW'(r_dx) + XW'(1);
                    end
                end
                CLEAR: begin
                    // The pixel registers double as the sweep counters.
                    if (oX_pixel == LAST_X && oY_pixel == LAST_Y) begin
                        r_state    <= IDLE;
                        oPlot      <= 1'b0;
                        oClearDone <= 1'b1;
                    end else if (oX_pixel == LAST_X) begin
                        oX_pixel <= '0;
                        oY_pixel <= oY_pixel + YW'(1);
                    end else begin
                        oX_pixel <= oX_pixel + XW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench: expected pixels are queued when a command is driven and
// popped by a negedge monitor whenever the arbiter plots.
module tb_vga_plot_arbiter;
    typedef struct packed { logic [9:0] x; logic [8:0] y; logic [8:0] c; } pix_t;

    logic        iClk = 1'b0, iResetn = 1'b0, iClear = 1'b0;
    logic [1:0]  iValid = 2'b00;
    logic [15:0] iCellX = '0, iCellY = '0;
    logic [17:0] iColour = '0;
    logic [1:0]  oReady;
    logic [9:0]  oX_pixel;
    logic [8:0]  oY_pixel, oColour;
    logic        oPlot, oBusy, oClearDone, oDropped;

    pix_t sb[$];
    int   n_vec = 0, n_err = 0;

    vga_plot_arbiter dut (
        .iClk(iClk), .iResetn(iResetn), .iValid(iValid), .iCellX(iCellX), .iCellY(iCellY),
        .iColour(iColour), .iClear(iClear), .oReady(oReady), .oX_pixel(oX_pixel),
        .oY_pixel(oY_pixel), .oColour(oColour), .oPlot(oPlot), .oBusy(oBusy),
        .oClearDone(oClearDone), .oDropped(oDropped)
    );

    always #5 iClk = ~iClk;

    always @(negedge iClk) begin
        if (iResetn && oPlot) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL plot_unexpected: got (%0d,%0d) col %h, expected no plot", oX_pixel, oY_pixel, oColour);
            end else begin
                pix_t e;
                e = sb.pop_front();
                if ({oX_pixel, oY_pixel, oColour} !== e) begin
                    n_err++;
                    $display("FAIL pixel: got (%0d,%0d) col %h, expected (%0d,%0d) col %h",
                             oX_pixel, oY_pixel, oColour, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    task automatic set_req(input int k, input int cx, input int cy, input logic [8:0] col);
        iCellX[k*8 +: 8]  = 8'(cx);
        iCellY[k*8 +: 8]  = 8'(cy);
        iColour[k*9 +: 9] = col;
    endtask

    task automatic push_cell(input int cx, input int cy, input logic [8:0] col);
        for (int dy = 0; dy < 5; dy++)
            for (int dx = 0; dx < 5; dx++)
                sb.push_back({10'(cx * 5 + dx), 9'(cy * 5 + dy), col});
    endtask

    task automatic run_cell(input string name);
        int gaps = 0;
        for (int i = 0; i < 25; i++) begin
            if (oPlot !== 1'b1) gaps++;
            tick;
        end
        n_vec++;
        if (gaps != 0) begin n_err++; $display("FAIL %s_gaps: got %0d missing plot cycles, expected 0", name, gaps); end
    endtask

    task automatic test_reset;
        iResetn = 1'b0; iValid = 2'b11;
        #3;
        n_vec++;
        if ({oPlot, oBusy, oClearDone, oDropped, oX_pixel, oY_pixel, oColour} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got plot=%b busy=%b done=%b drop=%b x=%0d y=%0d col=%h, expected all 0",
                     oPlot, oBusy, oClearDone, oDropped, oX_pixel, oY_pixel, oColour);
        end
        n_vec++;
        if (oReady !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b, expected 00", oReady); end
        @(negedge iClk);
        iResetn = 1'b1; iValid = 2'b10;
        #1;
        n_vec++;
        if (oReady !== 2'b10) begin n_err++; $display("FAIL reset_release_ready: got %b, expected 10", oReady); end
        iValid = 2'b00;
        tick;
    endtask

    task automatic test_single;
        set_req(0, 2, 3, 9'h1C0); iValid = 2'b01;
        #1;
        n_vec++;
        if (oReady !== 2'b01) begin n_err++; $display("FAIL single_ready: got %b, expected 01", oReady); end
        push_cell(2, 3, 9'h1C0);
        tick;
        iValid = 2'b00;
        run_cell("single");
        n_vec++;
        if (oPlot !== 1'b0 || oBusy !== 1'b0) begin
            n_err++; $display("FAIL single_end: got plot=%b busy=%b, expected 0 0", oPlot, oBusy);
        end
    endtask

    task automatic test_round_robin;
        iResetn = 1'b0; #1; iResetn = 1'b1;
        set_req(0, 4, 4, 9'h007); set_req(1, 6, 2, 9'h038); iValid = 2'b11;
        #1;
        for (int c = 0; c < 4; c++) begin
            logic [1:0] exp_r;
            exp_r = (c % 2 == 0) ? 2'b01 : 2'b10;
            n_vec++;
            if (oReady !== exp_r) begin n_err++; $display("FAIL rr_grant%0d: got %b, expected %b", c, oReady, exp_r); end
            if (c % 2 == 0) push_cell(4, 4, 9'h007); else push_cell(6, 2, 9'h038);
            tick;
            run_cell("rr");
        end
        iValid = 2'b00;
        n_vec++;
        if (oBusy !== 1'b0) begin n_err++; $display("FAIL rr_idle: got busy=%b, expected 0", oBusy); end
    endtask

    task automatic test_clear_mid_cell;
        int bad = 0;
        set_req(0, 1, 1, 9'h0AA); iValid = 2'b01;
        #1;
        push_cell(1, 1, 9'h0AA);
        tick;
        for (int i = 0; i < 25; i++) begin
            iClear = (i == 7);
            if (oPlot !== 1'b1 || oReady !== 2'b00) bad++;
            tick;
        end
        iClear = 1'b0;
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL clr_cell_intact: got %0d bad cycles, expected 0", bad); end
        n_vec++;
        if (oPlot !== 1'b0 || oReady !== 2'b00) begin
            n_err++; $display("FAIL clr_gap: got plot=%b ready=%b, expected 0 00", oPlot, oReady);
        end
        for (int y = 0; y < 240; y++)
            for (int x = 0; x < 320; x++)
                sb.push_back({10'(x), 9'(y), 9'h1FF});
        tick;
        bad = 0;
        for (int i = 0; i < 76800; i++) begin
            if (oPlot !== 1'b1 || oReady !== 2'b00 || oClearDone !== 1'b0) bad++;
            tick;
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL clr_sweep: got %0d bad cycles, expected 0", bad); end
        n_vec++;
        if (oClearDone !== 1'b1 || oPlot !== 1'b0 || oBusy !== 1'b0) begin
            n_err++; $display("FAIL clr_done: got done=%b plot=%b busy=%b, expected 1 0 0", oClearDone, oPlot, oBusy);
        end
        iValid = 2'b00;
        tick;
        n_vec++;
        if (oClearDone !== 1'b0) begin n_err++; $display("FAIL clr_done_pulse: got %b, expected 0", oClearDone); end
    endtask

    task automatic test_dropped;
        set_req(1, 64, 0, 9'h1FF); iValid = 2'b10;
        #1;
        n_vec++;
        if (oReady !== 2'b10) begin n_err++; $display("FAIL drop_ready: got %b, expected 10", oReady); end
        tick;
        iValid = 2'b00;
        n_vec++;
        if (oDropped !== 1'b1 || oPlot !== 1'b0 || oBusy !== 1'b0) begin
            n_err++; $display("FAIL drop_pulse: got drop=%b plot=%b busy=%b, expected 1 0 0", oDropped, oPlot, oBusy);
        end
        tick;
        n_vec++;
        if (oDropped !== 1'b0) begin n_err++; $display("FAIL drop_once: got %b, expected 0", oDropped); end
        iValid = 2'b11;
        #1;
        n_vec++;
        if (oReady !== 2'b01) begin n_err++; $display("FAIL drop_last_grant: got %b, expected 01", oReady); end
        set_req(0, 0, 48, 9'h001);
        tick;
        iValid = 2'b00;
        n_vec++;
        if (oDropped !== 1'b1 || oPlot !== 1'b0) begin
            n_err++; $display("FAIL drop_cy: got drop=%b plot=%b, expected 1 0", oDropped, oPlot);
        end
        tick;
    endtask

    task automatic test_corner;
        set_req(0, 63, 47, 9'h155); iValid = 2'b01;
        #1;
        push_cell(63, 47, 9'h155);
        tick;
        iValid = 2'b00;
        n_vec++;
        if (oX_pixel !== 10'd315 || oY_pixel !== 9'd235) begin
            n_err++; $display("FAIL corner_first: got (%0d,%0d), expected (315,235)", oX_pixel, oY_pixel);
        end
        run_cell("corner");
        n_vec++;
        if (oBusy !== 1'b0 || oDropped !== 1'b0) begin
            n_err++; $display("FAIL corner_end: got busy=%b drop=%b, expected 0 0", oBusy, oDropped);
        end
    endtask

    task automatic test_reset_mid;
        set_req(1, 10, 5, 9'h0F0); iValid = 2'b10;
        #1;
        push_cell(10, 5, 9'h0F0);
        tick;
        for (int i = 0; i < 12; i++) tick;
        iResetn = 1'b0;
        #1;
        n_vec++;
        if ({oPlot, oBusy, oClearDone, oDropped, oX_pixel, oY_pixel, oColour, oReady} !== '0) begin
            n_err++; $display("FAIL rst_mid_outputs: got plot=%b busy=%b x=%0d y=%0d col=%h ready=%b, expected all 0",
                              oPlot, oBusy, oX_pixel, oY_pixel, oColour, oReady);
        end
        n_vec++;
        if (sb.size() != 13) begin n_err++; $display("FAIL rst_mid_plotted: got %0d left, expected 13", sb.size()); end
        sb.delete();
        @(negedge iClk);
        iResetn = 1'b1;
        #1;
        n_vec++;
        if (oReady !== 2'b10 || oBusy !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_release: got ready=%b busy=%b, expected 10 0", oReady, oBusy);
        end
        iValid = 2'b11;
        #1;
        n_vec++;
        if (oReady !== 2'b01) begin n_err++; $display("FAIL rst_mid_grant: got %b, expected 01", oReady); end
        iValid = 2'b00;
        tick;
        tick;
        n_vec++;
        if (oPlot !== 1'b0) begin n_err++; $display("FAIL rst_mid_quiet: got plot=%b, expected 0", oPlot); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_clear_mid_cell;
        test_dropped;
        test_corner;
        test_reset_mid;
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d pending pixels, expected 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
